// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) constants, parity masks and FSM encoding; HAMMING_EXT_PARITY_EN widens the code to extended (8,4).
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
package hamming_pkg;
    localparam int DATA_BITS = 4;
`ifdef HAMMING_EXT_PARITY_EN
    localparam int CODE_BITS = 8;
`else
    localparam int CODE_BITS = 7;
`endif
    localparam int COUNT_BITS = 3;
    // Masks over data[3:0], where data[0] is d1 (the first bit pulled)
    localparam logic [DATA_BITS-1:0] P1_MASK = 4'b1011;
    localparam logic [DATA_BITS-1:0] P2_MASK = 4'b1101;
    localparam logic [DATA_BITS-1:0] P3_MASK = 4'b1110;
    typedef enum logic [2:0] {PULL_REQ, PULL_WAIT, ENCODE, PUSH_REQ, PUSH_WAIT} encState;
endpackage

// File: rtl/hamming74_encode_comb.sv
// hamming74_encode_comb: combinational 4->7 Hamming encoder, code[0] is position 1; adds p0 as code[7] under HAMMING_EXT_PARITY_EN.
module hamming74_encode_comb
    import hamming_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    output logic [CODE_BITS-1:0] code
);
    logic p1, p2, p3;
    logic [6:0] base;
    assign p1 = ^(data & P1_MASK);
    assign p2 = ^(data & P2_MASK);
    assign p3 = ^(data & P3_MASK);
    assign base = {data[3], data[2], data[1], p3, data[0], p2, p1};
`ifdef HAMMING_EXT_PARITY_EN
    assign code = {^base, base};
`else
    assign code = base;
`endif
endmodule

// File: rtl/hamming74_serial_encoder.sv
// hamming74_serial_encoder: pulls 4 bits, encodes, pushes the codeword bit-serially over req/ack handshakes.
// HAMMING_EXT_PARITY_EN selects the 8-bit extended codeword.
module hamming74_serial_encoder
    import hamming_pkg::*;
(
    input  logic clock,
    input  logic clear,
    output logic pullReq,
    input  logic pullAck,
    input  logic pullValue,
    output logic pushReq,
    output logic pushValue,
    input  logic pushAck,
    output logic wordDone
);
    localparam logic [COUNT_BITS-1:0] LAST_DATA = COUNT_BITS'(DATA_BITS - 1);
    localparam logic [COUNT_BITS-1:0] LAST_CODE = COUNT_BITS'(CODE_BITS - 1);
    encState state, stateNext;
    logic [COUNT_BITS-1:0] bitIdx, bitIdxNext;
    logic [DATA_BITS-1:0] data, dataNext;
    logic [CODE_BITS-1:0] code, codeNext, encoded;
    logic pushValueNext, wordDoneNext;

    hamming74_encode_comb encoder (.data(data), .code(encoded));

    // Req registers follow the next state, so a Req appears in the first cycle of its *_REQ state;
    // leaving clear the Req is still low, so PULL_REQ stays one extra cycle to raise it.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= PULL_REQ;
            bitIdx <= '0;
            data <= '0;
            code <= '0;
            pullReq <= `LOW;
            pushReq <= `LOW;
            pushValue <= `LOW;
            wordDone <= `LOW;
        end else begin
            state <= stateNext;
            bitIdx <= bitIdxNext;
            data <= dataNext;
            code <= codeNext;
            pullReq <= stateNext == PULL_REQ;
            pushReq <= stateNext == PUSH_REQ;
            pushValue <= pushValueNext;
            wordDone <= wordDoneNext;
        end
    end

    always_comb begin
        stateNext = state;
        bitIdxNext = bitIdx;
        dataNext = data;
        codeNext = code;
        pushValueNext = pushValue;
        wordDoneNext = `LOW;
        case (state)
            PULL_REQ: stateNext = pullReq ? PULL_WAIT : PULL_REQ;
            PULL_WAIT: if (pullAck) begin
                dataNext[bitIdx[1:0]] = pullValue;
                bitIdxNext = bitIdx == LAST_DATA ? '0 : bitIdx + 1'b1;
                stateNext = bitIdx == LAST_DATA ? ENCODE : PULL_REQ;
            end
            ENCODE: begin
                codeNext = encoded;
                pushValueNext = encoded[0];
                stateNext = PUSH_REQ;
            end
            PUSH_REQ: stateNext = pushReq ? PUSH_WAIT : PUSH_REQ;
            PUSH_WAIT: if (pushAck) begin
                bitIdxNext = bitIdx == LAST_CODE ? '0 : bitIdx + 1'b1;
                wordDoneNext = bitIdx == LAST_CODE;
                stateNext = bitIdx == LAST_CODE ? PULL_REQ : PUSH_REQ;
                pushValueNext = bitIdx == LAST_CODE ? pushValue : code[bitIdxNext];
            end
            default: stateNext = PULL_REQ;
        endcase
    end
endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// tb_hamming74_serial_encoder: FIFO-like responders plus a positional Hamming model; define HAMMING_EXT_PARITY_EN for the (8,4) build.
module tb_hamming74_serial_encoder;
`ifdef HAMMING_EXT_PARITY_EN
    localparam int CB = 8;
    localparam bit EXT = 1'b1;
`else
    localparam int CB = 7;
    localparam bit EXT = 1'b0;
`endif
    logic clock, clear, pullReq, pullAck, pullValue, pushReq, pushValue, pushAck, wordDone;
    int nChecks = 0, nFail = 0, cyc = 0;
    int pullDlyMax = 1, pushDlyMax = 1, drainPct = 100, downCnt = 0, upPopped = 0;
    bit drainHold = 1'b0;
    bit upQ[$];
    bit expQ[$];
    logic [7:0] rxWords[$];
    logic [7:0] rxAcc = '0;
    int rxCnt = 0;

    hamming74_serial_encoder dut (
        .clock(clock), .clear(clear),
        .pullReq(pullReq), .pullAck(pullAck), .pullValue(pullValue),
        .pushReq(pushReq), .pushValue(pushValue), .pushAck(pushAck),
        .wordDone(wordDone)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Positions 1..7; parity at power-of-two position p covers every position whose index has bit p set
    function automatic logic [7:0] encodeModel(input logic [3:0] w);
        logic [7:0] pos;
        logic [7:0] r;
        pos = '0;
        pos[3] = w[3];
        pos[5] = w[2];
        pos[6] = w[1];
        pos[7] = w[0];
        for (int p = 1; p < 8; p = p * 2)
            for (int k = 1; k < 8; k++)
                if ((k & p) != 0 && k != p) pos[p] = pos[p] ^ pos[k];
        r = '0;
        for (int k = 1; k < 8; k++) r = {r[6:0], pos[k]};
        if (EXT) r = {r[6:0], ^pos[7:1]};
        return r;
    endfunction

    function automatic logic [7:0] lit(input logic [6:0] a, input logic [7:0] b);
        return EXT ? b : {1'b0, a};
    endfunction

    task automatic loadWord(input logic [3:0] w);
        logic [7:0] c;
        c = encodeModel(w);
        for (int i = 3; i >= 0; i--) upQ.push_back(w[i]);
        for (int i = CB - 1; i >= 0; i--) expQ.push_back(c[i]);
    endtask

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic waitWords(input int n, input int budget, input string name);
        for (int i = 0; i < budget && rxWords.size() < n; i++) tick();
        check(name, rxWords.size() >= n, 1);
    endtask

    // Upstream and downstream responders: ack at least one cycle after Req, withhold when empty/full
    initial begin
        int pullPend, pushPend;
        pullPend = 0;
        pushPend = 0;
        pullAck = 1'b0;
        pullValue = 1'b0;
        pushAck = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            pullAck = 1'b0;
            pushAck = 1'b0;
            pullValue = 1'($urandom);
            if (!drainHold && downCnt > 0 && $urandom_range(99, 0) < drainPct) downCnt--;
            if (pullPend > 0) begin
                pullPend--;
                if (pullPend == 0) begin
                    if (upQ.size() > 0) begin
                        pullAck = 1'b1;
                        pullValue = upQ.pop_front();
                        upPopped++;
                    end else pullPend = 1;
                end
            end
            if (pushPend > 0) begin
                pushPend--;
                if (pushPend == 0) begin
                    if (downCnt < 4) begin
                        pushAck = 1'b1;
                        downCnt++;
                        rxAcc = {rxAcc[6:0], pushValue};
                        rxCnt++;
                        if (rxCnt == CB) begin
                            rxWords.push_back(EXT ? rxAcc : {1'b0, rxAcc[6:0]});
                            rxAcc = '0;
                            rxCnt = 0;
                        end
                    end else pushPend = 1;
                end
            end
            if (pullReq) pullPend = $urandom_range(pullDlyMax, 1);
            if (pushReq) pushPend = $urandom_range(pushDlyMax, 1);
        end
    end

    // Per-cycle compare against the model queue and the handshake rules
    initial begin
        int pushCount;
        bit doneDue, prevPull, prevPush, holdActive, holdVal;
        pushCount = 0;
        doneDue = 0;
        prevPull = 0;
        prevPush = 0;
        holdActive = 0;
        holdVal = 0;
        forever begin
            @(negedge clock);
            if (clear) begin
                pushCount = 0;
                doneDue = 0;
                prevPull = 0;
                prevPush = 0;
                holdActive = 0;
            end else begin
                check("wordDone", wordDone, doneDue);
                doneDue = 0;
                check("pullReq_one_cycle", pullReq && prevPull, 0);
                check("pushReq_one_cycle", pushReq && prevPush, 0);
                check("pullReq_during_ack", pullReq && pullAck, 0);
                check("pushReq_during_ack", pushReq && pushAck, 0);
                if (holdActive) check("pushValue_hold", pushValue, holdVal);
                if (pushReq) begin
                    holdActive = 1;
                    holdVal = pushValue;
                end
                if (pushAck) begin
                    check("push_expected", expQ.size() > 0, 1);
                    if (expQ.size() > 0) check("push_bit", pushValue, expQ.pop_front());
                    holdActive = 0;
                    pushCount++;
                    if (pushCount == CB) begin
                        pushCount = 0;
                        doneDue = 1;
                    end
                end
                prevPull = pullReq;
                prevPush = pushReq;
            end
        end
    end

    initial begin
        int start, base;
        logic pv;
        check("model_1011", encodeModel(4'b1011), lit(7'b0110011, 8'b01100110));
        check("model_1000", encodeModel(4'b1000), lit(7'b1110000, 8'b11100001));
        check("model_0110", encodeModel(4'b0110), lit(7'b1100110, 8'b11001100));
        clear = 1'b1;
        repeat (3) begin
            tick();
            check("clear_pullReq", pullReq, 0);
            check("clear_pushReq", pushReq, 0);
            check("clear_wordDone", wordDone, 0);
        end
        loadWord(4'b1011);
        clear = 1'b0;
        tick();
        check("release_pullReq", pullReq, 1);
        check("release_pushReq", pushReq, 0);
        check("release_wordDone", wordDone, 0);
        start = cyc;
        for (int i = 0; i < 200 && !wordDone; i++) tick();
        check("word_latency", cyc - start, EXT ? 25 : 23);
        check("word1011", rxWords[0], lit(7'b0110011, 8'b01100110));
        loadWord(4'b0000);
        loadWord(4'b1111);
        loadWord(4'b1000);
        waitWords(4, 500, "b2b_timeout");
        check("word0000", rxWords[1], lit(7'b0000000, 8'b00000000));
        check("word1111", rxWords[2], lit(7'b1111111, 8'b11111111));
        check("word1000", rxWords[3], lit(7'b1110000, 8'b11100001));
        drainHold = 1'b1;
        loadWord(4'b1011);
        loadWord(4'b0110);
        for (int i = 0; i < 200 && downCnt < 4; i++) tick();
        check("fill_timeout", downCnt, 4);
        tick();
        tick();
        pv = pushValue;
        check("stall_value_model", pv, expQ.size() > 0 ? expQ[0] : 1'bx);
        repeat (10) begin
            tick();
            check("stall_pushReq", pushReq, 0);
            check("stall_pushValue", pushValue, pv);
        end
        drainHold = 1'b0;
        waitWords(6, 500, "drain_timeout");
        check("resume1011", rxWords[4], lit(7'b0110011, 8'b01100110));
        check("resume0110", rxWords[5], lit(7'b1100110, 8'b11001100));
        base = upPopped;
        loadWord(4'b0101);
        for (int i = 0; i < 200 && upPopped < base + 2; i++) tick();
        check("partial_timeout", upPopped >= base + 2, 1);
        clear = 1'b1;
        tick();
        tick();
        upQ.delete();
        expQ.delete();
        rxAcc = '0;
        rxCnt = 0;
        clear = 1'b0;
        base = rxWords.size();
        loadWord(4'b1011);
        waitWords(base + 1, 500, "postclear_timeout");
        check("postclear_count", rxWords.size(), base + 1);
        check("postclear1011", rxWords[base], lit(7'b0110011, 8'b01100110));
        pullDlyMax = 4;
        pushDlyMax = 4;
        drainPct = 50;
        base = rxWords.size();
        for (int i = 0; i < 20; i++) loadWord(4'($urandom));
        waitWords(base + 20, 8000, "random_timeout");
        repeat (5) tick();
        check("expq_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
